// File: rtl/bram_pkg.sv
// Shared definitions for the 4096x8 block RAM and its reader/writer blocks.
package bram_pkg;

   localparam int BRAM_ADDR_W = 12;
   localparam int BRAM_DATA_W = 8;
   localparam int BRAM_LEN_W  = BRAM_ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry FIFO that catches RAM read data the downstream cannot take yet.
module bram_skid_fifo #(
   parameter int W = 9
)(
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         i_wr,
   input  logic [W-1:0] i_din,
   input  logic         i_rd,
   output logic [W-1:0] o_dout,
   output logic [1:0]   o_count,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;
   logic         w_do_wr;
   logic         w_do_rd;

   // A write into a full FIFO only proceeds if the head leaves in the same cycle.
   assign w_do_wr = i_wr & ((r_count != 2'd2) | i_rd);
   assign w_do_rd = i_rd & (r_count != 2'd0);

   assign o_dout  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_wr) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= ~r_wptr;
         end
         if (w_do_rd) r_rptr <= ~r_rptr;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read engine: turns (addr, len) commands into RAM reads and a byte stream.
// Read data is forwarded straight from the RAM when the skid FIFO is empty, so the
// first beat appears two cycles after command accept; the FIFO only fills on stalls.
module bram_burst_reader
   import bram_pkg::*;
#(
   parameter int ADDR_W = BRAM_ADDR_W,
   parameter int DATA_W = BRAM_DATA_W,
   parameter int LEN_W  = BRAM_LEN_W
)(
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_reset,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_rem;
   logic              r_inflight;
   logic              r_inflight_last;

   logic              w_accept;
   logic              w_start;
   logic              w_final_issue;
   logic              w_beat;
   logic [2:0]        w_occ;
   logic              w_fifo_wr;
   logic              w_fifo_rd;
   logic              w_fifo_empty;
   logic [1:0]        w_fifo_cnt;
   logic [DATA_W:0]   w_fifo_head;

   assign mem_we        = 1'b0;
   assign mem_reset     = 1'b0;
   assign mem_addr      = r_addr;

   assign w_accept      = cmd_valid & cmd_ready;
   assign w_start       = w_accept & (cmd_len != '0);
   assign w_final_issue = mem_en & (r_rem == LEN_W'(1));
   assign w_occ         = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};

   // Head of stream: FIFO entry if any, otherwise the read landing this cycle.
   assign out_valid = ~w_fifo_empty | r_inflight;
   assign out_data  = !w_fifo_empty ? w_fifo_head[DATA_W-1:0] :
                      (r_inflight ? mem_dout : '0);
   assign out_last  = !w_fifo_empty ? w_fifo_head[DATA_W] :
                      (r_inflight ? r_inflight_last : 1'b0);
   assign w_beat    = out_valid & out_ready;

   // Landing data goes to the FIFO unless it bypasses straight to a ready consumer.
   assign w_fifo_wr = r_inflight & ~(w_fifo_empty & out_ready);
   assign w_fifo_rd = ~w_fifo_empty & out_ready;

   bram_skid_fifo #(.W(DATA_W + 1)) u_skid (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .i_wr    (w_fifo_wr),
      .i_din   ({r_inflight_last, mem_dout}),
      .i_rd    (w_fifo_rd),
      .o_dout  (w_fifo_head),
      .o_count (w_fifo_cnt),
      .o_empty (w_fifo_empty)
   );

   // State register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = ISSUE;
         ISSUE:   if (w_final_issue) w_next = DRAIN;
         DRAIN:   if (w_beat & out_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs: issue only while fewer than two reads are buffered or in flight.
   always_comb begin
      cmd_ready = (r_state == IDLE);
      busy      = (r_state != IDLE);
      mem_en    = (r_state == ISSUE) && (w_occ < 3'd2);
   end

   // Address/length counters and the one-deep in-flight tracker.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_addr          <= '0;
         r_rem           <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         if (w_start) begin
            r_addr <= cmd_addr;
            r_rem  <= cmd_len;
         end else if (mem_en) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - LEN_W'(1);
         end
         r_inflight      <= mem_en;
         r_inflight_last <= w_final_issue;
      end
   end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a behavioural 4096x8 RAM.
module tb_bram_burst_reader;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [11:0] cmd_addr;
   logic [12:0] cmd_len;
   logic        mem_en;
   logic        mem_we;
   logic        mem_reset;
   logic [11:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;

   logic [7:0]  ram [4096];

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   int          issued   = 0;
   int          popped   = 0;
   int          max_out  = 0;
   logic        busy_at_last = 1'b0;
   logic [8:0]  beat_q [$];
   int          beat_cyc_q [$];
   logic [11:0] addr_q [$];
   int          en_cyc_q [$];

   bram_burst_reader dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_reset (mem_reset),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk_in = ~clk_in;

   // RAM with one-cycle read latency
   initial mem_dout = 8'h00;
   always @(posedge clk_in) if (mem_en) mem_dout <= ram[mem_addr];

   // Edge monitor: records accepts, reads issued and beats taken
   always @(posedge clk_in) begin
      if (rst_n) begin
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (mem_en) begin
            addr_q.push_back(mem_addr);
            en_cyc_q.push_back(cyc);
            issued++;
         end
         if (out_valid && out_ready) begin
            beat_q.push_back({out_last, out_data});
            beat_cyc_q.push_back(cyc);
            popped++;
            if (out_last) busy_at_last = busy;
         end
         if (issued - popped > max_out) max_out = issued - popped;
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear();
      beat_q.delete();
      beat_cyc_q.delete();
      addr_q.delete();
      en_cyc_q.delete();
      issued  = 0;
      popped  = 0;
      max_out = 0;
   endtask

   task automatic send_cmd(input logic [11:0] a, input logic [12:0] l);
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && beat_q.size() < n; i++) step();
      chk(tag, beat_q.size(), n);
   endtask

   initial begin
      logic [3:0] pat;
      logic       prev_stall;
      logic [7:0] prev_data;
      int         bad;
      int         lasts;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h05;
      step();
      step();

      // Reset values
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we_reset", {mem_we, mem_reset}, 0);
      rst_n = 1'b1;
      step();

      // 1: basic burst of 4, latency
      clear();
      send_cmd(12'h010, 13'd4);
      wait_beats("t1_count", 4, 50);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_beat%0d", i), beat_q[i], {(i == 3) ? 1'b1 : 1'b0, 8'h05});
         chk($sformatf("t1_addr%0d", i), addr_q[i], 12'h010 + 12'(i));
      end
      chk("t1_en_latency", en_cyc_q[0] - acc_cyc, 1);
      chk("t1_valid_latency", beat_cyc_q[0] - acc_cyc, 2);
      chk("t1_end_cycle", beat_cyc_q[3] - acc_cyc, 5);
      step();
      chk("t1_busy_after", busy, 0);
      chk("t1_no_extra", beat_q.size(), 4);

      // 2: address wrap
      for (int i = 0; i < 256; i++) ram[(12'hF80 + 12'(i))] = 8'(i);
      clear();
      send_cmd(12'hFFE, 13'd4);
      wait_beats("t2_count", 4, 50);
      chk("t2_addr0", addr_q[0], 12'hFFE);
      chk("t2_addr1", addr_q[1], 12'hFFF);
      chk("t2_addr2", addr_q[2], 12'h000);
      chk("t2_addr3", addr_q[3], 12'h001);
      chk("t2_data0", beat_q[0], 9'h07E);
      chk("t2_data1", beat_q[1], 9'h07F);
      chk("t2_data2", beat_q[2], 9'h080);
      chk("t2_data3", beat_q[3], 9'h181);
      step();

      // 3: backpressure 1,0,0,1 repeating
      for (int i = 0; i < 8; i++) ram[12'h100 + 12'(i)] = 8'hA0 + 8'(i);
      pat = 4'b1001;
      out_ready = 1'b0;
      clear();
      send_cmd(12'h100, 13'd8);
      for (int k = 0; k < 200 && beat_q.size() < 8; k++) begin
         out_ready  = pat[k % 4];
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         step();
         if (prev_stall) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, prev_data);
         end
      end
      chk("t3_count", beat_q.size(), 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t3_beat%0d", i), beat_q[i], {(i == 7) ? 1'b1 : 1'b0, 8'hA0 + 8'(i)});
      chk("t3_max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
      out_ready = 1'b1;
      step();
      step();
      chk("t3_busy_after", busy, 0);

      // 4: empty command
      clear();
      cmd_addr  = 12'h040;
      cmd_len   = 13'd0;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) bad++;
         step();
      end
      chk("t4_idle_flags_bad_cycles", bad, 0);
      chk("t4_no_reads", issued, 0);
      chk("t4_no_beats", beat_q.size(), 0);

      // 5: reset mid-burst
      clear();
      send_cmd(12'h200, 13'd16);
      for (int k = 0; k < 100 && beat_q.size() < 5; k++) step();
      chk("t5_pre_beats", beat_q.size(), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_mem_en", mem_en, 0);
      chk("t5_rst_mem_addr", mem_addr, 0);
      chk("t5_rst_cmd_ready", cmd_ready, 1);
      chk("t5_rst_out_data", out_data, 0);
      step();
      rst_n = 1'b1;
      clear();
      for (int k = 0; k < 5; k++) step();
      chk("t5_no_stale_beats", beat_q.size(), 0);
      chk("t5_no_stale_reads", issued, 0);
      send_cmd(12'h000, 13'd2);
      wait_beats("t5_count", 2, 50);
      step();
      step();
      chk("t5_exact_count", beat_q.size(), 2);
      chk("t5_beat0", beat_q[0], 9'h080);
      chk("t5_beat1", beat_q[1], 9'h181);

      // 6: maximum burst with full wrap
      clear();
      busy_at_last = 1'b0;
      send_cmd(12'h123, 13'd4096);
      wait_beats("t6_count", 4096, 5000);
      chk("t6_busy_falls", busy, 0);
      chk("t6_busy_on_last", busy_at_last, 1);
      chk("t6_end_cycle", beat_cyc_q[4095] - acc_cyc, 4097);
      chk("t6_addr_first", addr_q[0], 12'h123);
      chk("t6_addr_wrap", addr_q[12'hEDD], 12'h000);
      chk("t6_addr_lastaddr", addr_q[4095], 12'h122);
      bad   = 0;
      lasts = 0;
      for (int i = 0; i < 4096; i++) begin
         if (beat_q[i][7:0] !== ram[12'h123 + 12'(i)]) bad++;
         if (beat_q[i][8]) lasts++;
      end
      chk("t6_data_mismatches", bad, 0);
      chk("t6_single_last", lasts, 1);
      chk("t6_last_position", beat_q[4095][8], 1);
      chk("t6_max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
